fmac_norm_shift: RTL and testbench

FMAC_NORM_SHIFT -- requirements
Module: fmac_norm_shift

---
 rtl/fmac_norm_shift_pkg.sv | 21 ++
 rtl/fmac_norm_barrel.sv | 23 ++
 rtl/fmac_norm_shift.sv | 149 ++++++++++++++
 tb/tb_fmac_norm_shift.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fmac_norm_shift_pkg.sv
// Shared FPU constants for the FMAC normalization path: formats, exponent
// encodings and rounding modes used by the adder/normalizer stages.
package fmac_norm_shift_pkg;

    localparam int C_MANT          = 23;
    localparam int C_EXP           = 8;
    localparam int C_BIAS          = 127;
    localparam int C_LEADONE_WIDTH = 7;
    localparam int C_EXP_ZERO      = 0;
    // Product (2*(C_MANT+1)) plus aligned addend and two carry/guard bits.
    localparam int C_SUM_WIDTH     = 3 * (C_MANT + 1) + 2;

    typedef enum logic [2:0] {
        RM_RNE = 3'd0,
        RM_RTZ = 3'd1,
        RM_RDN = 3'd2,
        RM_RUP = 3'd3,
        RM_RMM = 3'd4
    } round_mode_e;

endpackage

// File: rtl/fmac_norm_barrel.sv
// Normalizing left shift of the FMAC sum, with the one-place fix-up for a
// leading-zero anticipator that undercounts by one.
module fmac_norm_barrel #(
    parameter int C_WIDTH         = fmac_norm_shift_pkg::C_SUM_WIDTH,
    parameter int C_LEADONE_WIDTH = fmac_norm_shift_pkg::C_LEADONE_WIDTH
) (
    input  logic [C_WIDTH-1:0]         sum_in,
    input  logic [C_LEADONE_WIDTH-1:0] shamt,
    input  logic                       clamp,
    output logic [C_WIDTH-1:0]         shifted,
    output logic                       corr
);

    logic [C_WIDTH-1:0] coarse;

    always_comb begin
        coarse  = sum_in << shamt;
        // A clamped shift is allowed to leave the MSB clear (subnormal result).
        corr    = ~coarse[C_WIDTH-1] & ~clamp;
        shifted = corr ? {coarse[C_WIDTH-2:0], 1'b0} : coarse;
    end

endmodule

// File: rtl/fmac_norm_shift.sv
// Two-stage FMAC normalizer: stage 1 derives the exponent-limited shift,
// stage 2 shifts, corrects the LZA error and splits mantissa/guard/sticky.
module fmac_norm_shift #(
    parameter int C_WIDTH         = fmac_norm_shift_pkg::C_SUM_WIDTH,
    parameter int C_LEADONE_WIDTH = fmac_norm_shift_pkg::C_LEADONE_WIDTH,
    parameter int C_MANT          = fmac_norm_shift_pkg::C_MANT,
    parameter int C_EXP           = fmac_norm_shift_pkg::C_EXP
) (
    input  logic                       Clk_CI,
    input  logic                       Rst_RBI,
    input  logic                       Flush_SI,
    input  logic                       Valid_SI,
    output logic                       Ready_SO,
    input  logic [C_WIDTH-1:0]         Sum_DI,
    input  logic [C_EXP+1:0]           Exp_DI,
    input  logic                       Sign_DI,
    input  logic [C_LEADONE_WIDTH-1:0] Lzc_DI,
    input  logic                       No_one_SI,
    output logic                       Valid_SO,
    input  logic                       Ready_SI,
    output logic [C_MANT:0]            Mant_DO,
    output logic                       Guard_SO,
    output logic                       Sticky_SO,
    output logic [C_EXP+1:0]           Exp_DO,
    output logic                       Sign_DO,
    output logic                       Zero_SO,
    output logic                       Denorm_SO
);

    import fmac_norm_shift_pkg::*;

    localparam int EW = C_EXP + 2;
    localparam int XW = C_EXP + 3;
    localparam logic signed [XW-1:0] ONE_X     = 1;
    localparam logic signed [EW-1:0] EXP_ZERO  = EW'(C_EXP_ZERO);

    // Handshake: a stage takes new data when it is empty or its consumer takes
    // its current data this cycle; valid/ready transfer on the same edge.
    logic s1_valid, s1_accept, s2_accept;

    assign s2_accept = ~Valid_SO | Ready_SI;
    assign s1_accept = ~s1_valid | s2_accept;
    assign Ready_SO  = s1_accept;

    logic signed [XW-1:0]       exp_m1, lzc_ext;
    logic                       clamp_d, zero_d;
    logic [C_LEADONE_WIDTH-1:0] shamt_d;

    // The shift may not drive the exponent below 1; beyond that the result is subnormal.
    always_comb begin
        exp_m1  = $signed({Exp_DI[EW-1], Exp_DI}) - ONE_X;
        lzc_ext = $signed({{(XW-C_LEADONE_WIDTH){1'b0}}, Lzc_DI});
        clamp_d = (exp_m1 <= lzc_ext);
        zero_d  = No_one_SI | ~|Sum_DI;
        if (!clamp_d)
            shamt_d = Lzc_DI;
        else if (exp_m1[XW-1])
            shamt_d = '0;
        else
            shamt_d = exp_m1[C_LEADONE_WIDTH-1:0];
    end

    logic [C_WIDTH-1:0]         s1_sum;
    logic [EW-1:0]              s1_exp;
    logic                       s1_sign, s1_zero, s1_clamp;
    logic [C_LEADONE_WIDTH-1:0] s1_shamt;

    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            s1_valid <= 1'b0;
            Valid_SO <= 1'b0;
        end else if (Flush_SI) begin
            s1_valid <= 1'b0;
            Valid_SO <= 1'b0;
        end else begin
            if (s1_accept) s1_valid <= Valid_SI;
            if (s2_accept) Valid_SO <= s1_valid;
        end
    end

    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            s1_sum   <= '0;
            s1_exp   <= '0;
            s1_sign  <= 1'b0;
            s1_zero  <= 1'b0;
            s1_clamp <= 1'b0;
            s1_shamt <= '0;
        end else if (s1_accept && Valid_SI) begin
            s1_sum   <= Sum_DI;
            s1_exp   <= Exp_DI;
            s1_sign  <= Sign_DI;
            s1_zero  <= zero_d;
            s1_clamp <= clamp_d;
            s1_shamt <= shamt_d;
        end
    end

    logic [C_WIDTH-1:0] shifted;
    logic               corr;

    fmac_norm_barrel #(
        .C_WIDTH         (C_WIDTH),
        .C_LEADONE_WIDTH (C_LEADONE_WIDTH)
    ) u_barrel (
        .sum_in  (s1_sum),
        .shamt   (s1_shamt),
        .clamp   (s1_clamp),
        .shifted (shifted),
        .corr    (corr)
    );

    logic [EW-1:0] exp_res;
    logic          denorm_d;

    always_comb begin
        exp_res  = s1_exp - {{(EW-C_LEADONE_WIDTH){1'b0}}, s1_shamt} - {{(EW-1){1'b0}}, corr};
        denorm_d = ~s1_zero & ((s1_clamp & ~shifted[C_WIDTH-1]) | ($signed(exp_res) <= EXP_ZERO));
    end

    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            Mant_DO   <= '0;
            Guard_SO  <= 1'b0;
            Sticky_SO <= 1'b0;
            Exp_DO    <= '0;
            Sign_DO   <= 1'b0;
            Zero_SO   <= 1'b0;
            Denorm_SO <= 1'b0;
        end else if (s2_accept && s1_valid) begin
            Sign_DO <= s1_sign;
            Zero_SO <= s1_zero;
            if (s1_zero) begin
                Mant_DO   <= '0;
                Guard_SO  <= 1'b0;
                Sticky_SO <= 1'b0;
                Exp_DO    <= EXP_ZERO;
                Denorm_SO <= 1'b0;
            end else begin
                Mant_DO   <= shifted[C_WIDTH-1 -: C_MANT+1];
                Guard_SO  <= shifted[C_WIDTH-C_MANT-2];
                Sticky_SO <= |shifted[C_WIDTH-C_MANT-3:0];
                Exp_DO    <= denorm_d ? EXP_ZERO : exp_res;
                Denorm_SO <= denorm_d;
            end
        end
    end

endmodule

// File: tb/tb_fmac_norm_shift.sv
// Bench for fmac_norm_shift: directed corner vectors plus randomized traffic
// checked against a leading-one based reference model and an expected queue.
module tb_fmac_norm_shift;

  localparam int W  = 74;
  localparam int LW = 7;
  localparam int M  = 23;
  localparam int E  = 8;
  localparam int RW = (M + 1) + 1 + 1 + (E + 2) + 1 + 1 + 1;

  logic            Clk_CI = 1'b0;
  logic            Rst_RBI = 1'b1;
  logic            Flush_SI = 1'b0;
  logic            Valid_SI = 1'b0;
  logic            Ready_SO;
  logic [W-1:0]    Sum_DI = '0;
  logic [E+1:0]    Exp_DI = '0;
  logic            Sign_DI = 1'b0;
  logic [LW-1:0]   Lzc_DI = '0;
  logic            No_one_SI = 1'b0;
  logic            Valid_SO;
  logic            Ready_SI = 1'b1;
  logic [M:0]      Mant_DO;
  logic            Guard_SO, Sticky_SO;
  logic [E+1:0]    Exp_DO;
  logic            Sign_DO, Zero_SO, Denorm_SO;
  logic [RW-1:0]   out_vec;

  int n_checks = 0;
  int n_errors = 0;
  logic [RW-1:0] exp_q[$];

  // clock / reset
  always #5 Clk_CI = ~Clk_CI;

  fmac_norm_shift dut (
    .Clk_CI    (Clk_CI),
    .Rst_RBI   (Rst_RBI),
    .Flush_SI  (Flush_SI),
    .Valid_SI  (Valid_SI),
    .Ready_SO  (Ready_SO),
    .Sum_DI    (Sum_DI),
    .Exp_DI    (Exp_DI),
    .Sign_DI   (Sign_DI),
    .Lzc_DI    (Lzc_DI),
    .No_one_SI (No_one_SI),
    .Valid_SO  (Valid_SO),
    .Ready_SI  (Ready_SI),
    .Mant_DO   (Mant_DO),
    .Guard_SO  (Guard_SO),
    .Sticky_SO (Sticky_SO),
    .Exp_DO    (Exp_DO),
    .Sign_DO   (Sign_DO),
    .Zero_SO   (Zero_SO),
    .Denorm_SO (Denorm_SO)
  );

  assign out_vec = {Mant_DO, Guard_SO, Sticky_SO, Exp_DO, Sign_DO, Zero_SO, Denorm_SO};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  // Reference: normalize on the true leading one; if that would push the
  // exponent below 1, shift only down to exponent 1 and report a subnormal.
  function automatic logic [RW-1:0] model(input logic [W-1:0] sum, input logic signed [E+1:0] e,
                                          input logic no_one, input logic sign);
    int tlz, ei, sh, eo;
    logic den;
    logic [W-1:0] s;
    if (no_one || sum == '0)
      return {{(M+1){1'b0}}, 1'b0, 1'b0, {(E+2){1'b0}}, sign, 1'b1, 1'b0};
    tlz = W;
    for (int i = W - 1; i >= 0; i--) begin
      if (sum[i] && tlz == W) tlz = W - 1 - i;
    end
    ei = int'(e);
    if (ei - 1 >= tlz) begin
      sh = tlz; eo = ei - tlz; den = 1'b0;
    end else begin
      sh = (ei - 1 > 0) ? ei - 1 : 0; eo = 0; den = 1'b1;
    end
    s = sum << sh;
    return {s[W-1 -: M+1], s[W-M-2], |s[W-M-3:0], (E+2)'(eo), sign, 1'b0, den};
  endfunction

  // scoreboard: push on input transfer, compare every valid cycle, pop on output transfer
  always @(negedge Clk_CI) begin
    if (!Rst_RBI) begin
      exp_q.delete();
    end else begin
      check("ready", Ready_SO, (exp_q.size() < 2) || Ready_SI);
      if (Valid_SO) begin
        if (exp_q.size() == 0) check("stale_valid", Valid_SO, 0);
        else begin
          check("result", out_vec, exp_q[0]);
          if (Ready_SI) void'(exp_q.pop_front());
        end
      end
      if (Flush_SI) exp_q.delete();
      else if (Valid_SI && Ready_SO) exp_q.push_back(model(Sum_DI, Exp_DI, No_one_SI, Sign_DI));
    end
  end

  // driver tasks
  task automatic align();
    @(posedge Clk_CI); #1;
  endtask

  task automatic drive(input logic [W-1:0] s, input int e, input int l, input logic no, input logic sg);
    Sum_DI = s; Exp_DI = (E+2)'(e); Lzc_DI = LW'(l); No_one_SI = no; Sign_DI = sg;
  endtask

  task automatic rand_stim();
    logic [W-1:0] r, one, s;
    int p, tlz, l, e, pick;
    r   = W'({$urandom(), $urandom(), $urandom()});
    one = W'(1);
    p   = $urandom_range(0, W - 1);
    s   = (one << p) | (r & ((one << p) - one));
    tlz = W - 1 - p;
    l   = (tlz > 0 && $urandom_range(0, 1) == 1) ? tlz - 1 : tlz;
    if ($urandom_range(0, 15) == 0) begin
      s = '0; l = $urandom_range(0, W - 1);
    end
    pick = $urandom_range(0, 19);
    if (pick == 0) e = -512;
    else if (pick == 1) e = 511;
    else if (pick == 2) e = $urandom_range(0, 1);
    else e = int'($urandom_range(0, 199)) - 40;
    drive(s, e, l, ($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)));
  endtask

  task automatic accept_wait();
    int t = 0;
    @(negedge Clk_CI);
    while (!Ready_SO && t < 50) begin @(negedge Clk_CI); t++; end
    check("accept", Ready_SO, 1);
    @(posedge Clk_CI); #1;
    Valid_SI = 1'b0;
  endtask

  task automatic send(input logic [W-1:0] s, input int e, input int l, input logic no, input logic sg);
    drive(s, e, l, no, sg); Valid_SI = 1'b1; accept_wait();
  endtask

  task automatic send_rand();
    rand_stim(); Valid_SI = 1'b1; accept_wait();
  endtask

  task automatic wait_out();
    int t = 0;
    @(negedge Clk_CI);
    while (!Valid_SO && t < 20) begin @(negedge Clk_CI); t++; end
    check("out_valid", Valid_SO, 1);
  endtask

  initial begin
    logic acc;
    #2 Rst_RBI = 1'b0;
    #10;
    check("rst_valid", Valid_SO, 0);
    check("rst_ready", Ready_SO, 1);
    check("rst_data", out_vec, 0);
    align(); Rst_RBI = 1'b1;
    repeat (2) @(posedge Clk_CI);

    // normal case with exact LZC, including 2-cycle latency
    align();
    send(W'(1) << 68, 100, 5, 1'b0, 1'b0);
    @(negedge Clk_CI); check("lat1", Valid_SO, 0);
    @(negedge Clk_CI); check("lat2", Valid_SO, 1);
    check("n_mant", Mant_DO, 24'h800000);
    check("n_exp", Exp_DO, 95);
    check("n_guard", Guard_SO, 0);
    check("n_sticky", Sticky_SO, 0);
    check("n_denorm", Denorm_SO, 0);

    // LZC one short: correction shift
    align();
    send(W'(1) << 68, 100, 4, 1'b0, 1'b0);
    wait_out();
    check("c_mant", Mant_DO, 24'h800000);
    check("c_exp", Exp_DO, 95);

    // exponent-limited shift gives a subnormal
    align();
    send((W'(1) << 60) | W'(1), 5, 13, 1'b0, 1'b1);
    wait_out();
    check("d_exp", Exp_DO, 0);
    check("d_denorm", Denorm_SO, 1);
    check("d_sticky", Sticky_SO, 1);
    check("d_mant", Mant_DO, 24'h004000);

    // no leading one: zero result keeps its sign
    align();
    send(W'(12345), 77, 3, 1'b1, 1'b1);
    wait_out();
    check("z_zero", Zero_SO, 1);
    check("z_sign", Sign_DO, 1);
    check("z_rest", {Mant_DO, Guard_SO, Sticky_SO, Exp_DO, Denorm_SO}, 0);

    // back-to-back with downstream stalled for 3 cycles
    align();
    Ready_SI = 1'b0;
    send_rand(); send_rand();
    fork
      begin repeat (3) @(posedge Clk_CI); #1 Ready_SI = 1'b1; end
      begin @(negedge Clk_CI); check("full_ready", Ready_SO, 0); end
      send_rand();
    join
    repeat (6) @(posedge Clk_CI);
    check("stall_drain", exp_q.size(), 0);

    // flush with two results in flight, simultaneous input dropped
    align();
    Ready_SI = 1'b0;
    send_rand(); send_rand();
    rand_stim(); Valid_SI = 1'b1; Flush_SI = 1'b1;
    align();
    Flush_SI = 1'b0; Valid_SI = 1'b0;
    @(negedge Clk_CI); check("flush_valid", Valid_SO, 0);
    Ready_SI = 1'b1;
    repeat (4) begin @(negedge Clk_CI); check("flush_stale", Valid_SO, 0); end

    // reset with two results in flight
    align();
    Ready_SI = 1'b0;
    send_rand(); send_rand();
    Rst_RBI = 1'b0;
    #2;
    check("mrst_valid", Valid_SO, 0);
    check("mrst_ready", Ready_SO, 1);
    check("mrst_data", out_vec, 0);
    align();
    Rst_RBI = 1'b1; Ready_SI = 1'b1;
    align();
    send_rand();
    wait_out();

    // randomized traffic with random backpressure and occasional flush
    align();
    for (int c = 0; c < 3000; c++) begin
      @(negedge Clk_CI); acc = Valid_SI && Ready_SO;
      @(posedge Clk_CI); #1;
      Flush_SI = ($urandom_range(0, 99) == 0);
      Ready_SI = ($urandom_range(0, 9) < 7);
      if (acc || !Valid_SI) begin
        Valid_SI = ($urandom_range(0, 3) != 0);
        rand_stim();
      end
    end
    Valid_SI = 1'b0; Flush_SI = 1'b0; Ready_SI = 1'b1;
    repeat (6) @(posedge Clk_CI);
    check("final_drain", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
